// File: rtl/edge_mux_operand_driver_if.sv
// Operand and result valid/ready handshakes
// for the dual-edge operand driver.
interface edge_mux_operand_driver_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_err;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_err
  );
endinterface

// File: rtl/edge_mux_operand_driver.sv
// Drives an operand pair onto a shared pin bus with a
// generated pin clock, then samples and checks the sum.
module edge_mux_operand_driver #(
  parameter int WIDTH         = 7,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  edge_mux_operand_driver_if.slave   bus,
  output logic                       dut_clk,
  output logic [WIDTH-1:0]           dut_ab,
  input  logic [WIDTH-1:0]           dut_s,
  input  logic                       dut_c,
  output logic [7:0]                 err_count
);

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_CAPT,
    B_SETUP,
    B_CAPT,
    SETTLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST =
    4'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH:0]   out_sum_q;
  logic             out_err_q;

  logic             accept;
  logic             settle_last;
  logic [WIDTH:0]   ref_sum;
  logic [WIDTH:0]   sample;
  logic             mismatch;
  logic             clk_nx;
  logic [WIDTH-1:0] ab_nx;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_err   = out_err_q;

  assign accept      = bus.in_valid && in_ready_q;
  assign settle_last = (state == SETTLE) &&
                       (cnt_q == CNT_LAST);
  assign ref_sum     = {1'b0, a_q} + {1'b0, b_q};
  assign sample      = {dut_c, dut_s};
  assign mismatch    = (sample != ref_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = A_SETUP;
      A_SETUP: state_nx = A_CAPT;
      A_CAPT:  state_nx = B_SETUP;
      B_SETUP: state_nx = B_CAPT;
      B_CAPT:  state_nx = SETTLE;
      SETTLE:  if (settle_last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pins are registered from the current state, so the bus
  // and pin clock never move on the same clk edge.
  always_comb begin
    clk_nx = 1'b1;
    ab_nx  = '0;
    unique case (1'b1)
      state == A_SETUP: ab_nx = a_q;
      state == A_CAPT: begin
        clk_nx = 1'b0;
        ab_nx  = a_q;
      end
      state == B_SETUP: begin
        clk_nx = 1'b0;
        ab_nx  = b_q;
      end
      state == B_CAPT,
      state == SETTLE: ab_nx = b_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
      err_count   <= '0;
      dut_clk     <= 1'b1;
      dut_ab      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
    end else begin
      in_ready_q  <= (state_nx == IDLE);
      out_valid_q <= (state_nx == DONE);
      dut_clk     <= clk_nx;
      dut_ab      <= ab_nx;
      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      if (state == B_CAPT)
        cnt_q <= '0;
      else if (state == SETTLE)
        cnt_q <= cnt_q + 4'd1;
      if (settle_last) begin
        out_sum_q <= sample;
        out_err_q <= mismatch;
        if (mismatch && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_edge_mux_operand_driver.sv
// Randomised bench for the dual-edge operand driver
// against an edge-capturing adder and a reference model.
module tb_edge_mux_operand_driver;
  localparam int W = 7;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         dut_clk;
  logic [W-1:0] dut_ab;
  logic [W-1:0] dut_s;
  logic         dut_c;
  logic [7:0]   err_count;
  logic         fault = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since = 0;

  edge_mux_operand_driver_if #(.WIDTH(W)) bus();

  edge_mux_operand_driver #(
    .WIDTH(W),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dut_clk(dut_clk),
    .dut_ab(dut_ab),
    .dut_s(dut_s),
    .dut_c(dut_c),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Edge-capturing adder on the far side of the pins
  logic [W-1:0] cap_a = '0;
  logic [W-1:0] cap_b = '0;
  logic [W:0]   raw;
  always @(negedge dut_clk) cap_a = dut_ab;
  always @(posedge dut_clk) cap_b = dut_ab;
  assign raw   = {1'b0, cap_a} + {1'b0, cap_b};
  assign dut_s = raw[W-1:0] & {{(W-1){1'b1}}, ~fault};
  assign dut_c = raw[W];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    since = reset ? 0 : since + 1;
  end

  // Reference model and protocol monitor
  bit         pend = 0;
  int         acc = 0;
  logic [W-1:0] ma, mb;
  logic [W:0] tsum, msum;
  bit         merr;
  int         mcnt = 0;
  int         falls = 0, rises = 0;
  logic       pclk;
  logic [W-1:0] pab;
  bit         pvalid = 0;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0; mcnt = 0; falls = 0; rises = 0;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_dut_clk", dut_clk, 1);
      chk("rst_dut_ab", dut_ab, 0);
    end else begin
      if (pend && cyc == acc + 4 + S && merr && mcnt < 255)
        mcnt++;
      chk("in_ready", bus.in_ready, !pend && since >= 1);
      chk("out_valid", bus.out_valid,
          pend && cyc >= acc + 4 + S);
      chk("err_count", err_count, mcnt);
      if (pend && cyc >= acc + 4 + S) begin
        chk("out_sum", bus.out_sum, msum);
        chk("out_err", bus.out_err, merr);
      end
      if (!pend) begin
        chk("idle_clk", dut_clk, 1);
        chk("idle_ab", dut_ab, 0);
      end
      if (pvalid) begin
        chk("ab_moves_on_clk_edge",
            (dut_clk != pclk) && (dut_ab != pab), 0);
        if (pclk && !dut_clk) begin
          falls++;
          chk("fall_cycle", cyc, acc + 2);
          chk("bus_at_fall", dut_ab, ma);
        end
        if (!pclk && dut_clk) begin
          rises++;
          chk("rise_cycle", cyc, acc + 4);
          chk("bus_at_rise", dut_ab, mb);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("falls_per_tx", falls, 1);
        chk("rises_per_tx", rises, 1);
        pend = 0; falls = 0; rises = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        pend = 1;
        acc  = cyc + 1;
        ma   = bus.in_a;
        mb   = bus.in_b;
        tsum = {1'b0, ma} + {1'b0, mb};
        msum = fault ? {tsum[W:1], 1'b0} : tsum;
        merr = (msum != tsum);
      end
    end
    pclk   = dut_clk;
    pab    = dut_ab;
    pvalid = !reset;
  end

  task automatic wait_ready();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.in_ready && n < 50);
    chk("accept_timeout", bus.in_ready, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.out_valid && n < 100);
    chk("result_timeout", bus.out_valid, 1);
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input int hold,
                      output logic [W:0] s,
                      output logic e,
                      output int lat);
    int t0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    wait_ready();
    @(posedge clk); #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
    wait_valid();
    lat = cyc - t0;
    s   = bus.out_sum;
    e   = bus.out_err;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [W:0] s;
  logic       e;
  int         lat;
  int         h;
  int         t0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_dut_clk", dut_clk, 1);
    chk("post_rst_dut_ab", dut_ab, 0);
    chk("post_rst_err_count", err_count, 0);
    @(posedge clk); #1;
    chk("first_in_ready", bus.in_ready, 1);

    send(7'd5, 7'd3, 0, s, e, lat);
    chk("basic_sum", s, 8'h08);
    chk("basic_err", e, 0);
    chk("basic_latency", lat, 6);
    chk("basic_err_count", err_count, 0);

    send(7'd127, 7'd1, 0, s, e, lat);
    chk("carry_sum", s, 8'h80);
    chk("carry_err", e, 0);
    send(7'd127, 7'd127, 0, s, e, lat);
    chk("max_sum", s, 8'hFE);

    fault = 1'b1;
    send(7'd1, 7'd0, 0, s, e, lat);
    chk("fault_sum", s, 8'h00);
    chk("fault_err", e, 1);
    chk("fault_err_count", err_count, 1);
    for (int i = 0; i < 299; i++)
      send(7'd1, 7'd0, 0, s, e, lat);
    chk("sat_err_count", err_count, 255);
    fault = 1'b0;

    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 7'd10;
    bus.in_b      = 7'd20;
    bus.out_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    bus.in_a = 7'd11;
    bus.in_b = 7'd12;
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("bp_sum", bus.out_sum, 8'h1E);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 h = cyc;
    @(negedge clk);
    chk("b2b_ready_after_done", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_accepted", bus.in_ready, 0);
    wait_valid();
    chk("b2b_latency", cyc - (h + 1), 6);
    chk("b2b_sum", bus.out_sum, 8'h17);

    for (int i = 0; i < 150; i++) begin
      fault = ($urandom_range(0, 3) == 0);
      send(W'($urandom), W'($urandom),
           $urandom_range(0, 3), s, e, lat);
    end
    fault = 1'b0;

    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 7'd9;
    bus.in_b     = 7'd9;
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t0 = cyc;
    repeat (2) @(posedge clk);
    #2;
    chk("midop_pre_clk", dut_clk, 0);
    reset = 1'b1;
    #1;
    chk("midop_dut_clk", dut_clk, 1);
    chk("midop_dut_ab", dut_ab, 0);
    chk("midop_out_valid", bus.out_valid, 0);
    chk("midop_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    send(7'd2, 7'd2, 0, s, e, lat);
    chk("after_rst_sum", s, 8'h04);
    chk("after_rst_err", e, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/edge_mux_operand_driver.md
# edge_mux_operand_driver

Host-side driver for the shared-pin, dual-edge operand interface of the carry-look-ahead adder top. It accepts an operand pair over a valid/ready handshake and sequences it onto the 7-bit shared bus with a generated, registered pin clock: `a` is captured on the pin clock's falling edge and `b` on its rising edge. After a settle interval it samples the adder's sum and carry pins, checks them against a local reference sum, and returns the result over a second valid/ready handshake.

## Interface
- WIDTH, 7, operand width; also the shared-bus and sum-pin width.
- SETTLE_CYCLES, 2, cycles between the `b` capture edge and result sampling; legal range 1..15.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  driver can accept an operand pair.
- in_a  input  WIDTH  operand captured by the DUT on its pin-clock falling edge.
- in_b  input  WIDTH  operand captured by the DUT on its pin-clock rising edge.
- dut_clk  output  1  registered pin clock to the DUT (io_in[0]).
- dut_ab  output  WIDTH  registered shared operand bus to the DUT (io_in[WIDTH:1]).
- dut_s  input  WIDTH  DUT sum pins (io_out[WIDTH:1]).
- dut_c  input  1  DUT carry pin (io_out[0]).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH+1  sampled result, {dut_c, dut_s}.
- out_err  output  1  sampled result differs from in_a + in_b.
- err_count  output  8  saturating mismatch counter.

## Operation
- Capture: in_valid && in_ready latches in_a and in_b into internal registers. The reference sum is computed as the (WIDTH+1)-bit zero-extended sum of the latched operands, with no truncation.
- FSM states: IDLE, A_SETUP, A_CAPT, B_SETUP, B_CAPT, SETTLE, DONE.
  - IDLE: dut_clk=1, dut_ab=0, in_ready=1. On accept, go to A_SETUP.
  - A_SETUP: dut_ab=a, dut_clk=1. 1 cycle.
  - A_CAPT: dut_ab=a, dut_clk=0; the falling edge captures `a`. 1 cycle.
  - B_SETUP: dut_ab=b, dut_clk=0. 1 cycle.
  - B_CAPT: dut_ab=b, dut_clk=1; the rising edge captures `b`. 1 cycle.
  - SETTLE: bus and clock held as in B_CAPT. A 4-bit counter runs SETTLE_CYCLES cycles. On the last cycle, the edge loads out_sum={dut_c,dut_s} and out_err=(out_sum != reference), and the state becomes DONE.
  - DONE: out_valid=1; out_sum and out_err are stable. On out_ready, go to IDLE.
- dut_ab changes only while dut_clk is steady, never in the same cycle as a dut_clk transition. This guarantees one full clk cycle of setup and hold around each pin-clock edge.
- err_count increments by 1 on entry to DONE with out_err=1. It saturates at 255 and is cleared only by reset.
- in_ready=0 in every state except IDLE. Operands are never accepted while a transaction is in flight.

## Timing
- Reset values: state=IDLE, dut_clk=1, dut_ab=0, in_ready=1 after reset deasserts (0 while reset is asserted), out_valid=0, out_sum=0, out_err=0, err_count=0.
- Reset mid-transaction: all outputs return asynchronously to their reset values, and the in-flight pair is discarded with no result produced.
- Latency: with the accept edge at cycle 0, dut_clk falls at cycle 2 and rises at cycle 4. out_valid asserts at cycle 4+SETTLE_CYCLES (6 at the defaults).
- Throughput: with out_ready held at 1, a new accept occurs 1 cycle after the DONE handshake, giving one transaction per 6+SETTLE_CYCLES cycles.
- Backpressure: DONE holds indefinitely. out_sum, out_err and out_valid stay stable until out_ready is asserted.
- in_valid arriving while busy is ignored; the source must hold in_a, in_b and in_valid until in_ready.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Basic: the bench models the DUT as an edge-capturing adder. a=5, b=3 -> out_sum=0x08, out_err=0, out_valid at cycle 6, err_count=0.
- Carry/wrap: a=127, b=1 -> out_sum=0x80 (carry=1, sum=0), out_err=0. a=127, b=127 -> out_sum=0xFE.
- Faulty DUT: bench forces dut_s[0] stuck at 0. a=1, b=0 -> out_sum=0x00, out_err=1, err_count=1. Repeating this 300 times leaves err_count=255.
- Backpressure/back-to-back: out_ready held low 10 cycles with a=10, b=20 -> out_sum=0x1E stays stable and in_ready=0 throughout. After out_ready, the next pair is accepted on the cycle after returning to IDLE.
- Protocol check: a monitor verifies dut_ab never changes in the same cycle as a dut_clk transition, the pin clock shows exactly one fall and one rise per transaction, and the bus carries `a` at the fall and `b` at the rise.
- Reset mid-op: reset asserted during B_SETUP -> dut_clk=1, dut_ab=0 and out_valid=0 immediately, with no result emitted. The next pair a=2, b=2 -> out_sum=0x04.
